// File: rtl/bypass_scoreboard_unit.sv
// ID-stage operand bypass and interlock across NUM_FWD forwarding stages, plus a
// per-register busy scoreboard for long-latency results that retire on a dedicated port.

module bypass_scoreboard_port #(
    parameter int NUM_FWD = 3,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int NREG    = 32
) (
    input  logic                             rd_en,
    input  logic [AW-1:0]                    rd_addr,
    input  logic [DW-1:0]                    rd_data_rf,
    input  logic [NUM_FWD-1:0]               fwd_valid,
    input  logic [NUM_FWD-1:0]               fwd_we,
    input  logic [NUM_FWD-1:0]               fwd_ready,
    input  logic [NUM_FWD-1:0][AW-1:0]       fwd_waddr,
    input  logic [NUM_FWD-1:0][DW-1:0]       fwd_wdata,
    input  logic                             ret_valid,
    input  logic [AW-1:0]                    ret_waddr,
    input  logic [DW-1:0]                    ret_wdata,
    input  logic [NREG-1:0]                  sb_busy,
    output logic [DW-1:0]                    rd_data_byp,
    output logic                             raw_pipe,
    output logic                             raw_sb
);
    logic               addr_nz;
    logic               ret_hit;
    logic [NUM_FWD-1:0] match;

    assign addr_nz = (rd_addr != '0);
    assign ret_hit = ret_valid & addr_nz & (ret_waddr == rd_addr);

    always_comb begin
        match = '0;
        for (int s = 0; s < NUM_FWD; s++)
            match[s] = rd_en & addr_nz & fwd_valid[s] & fwd_we[s] & (fwd_waddr[s] == rd_addr);
    end

    // Walk oldest to youngest so the youngest matching stage wins and hides older ones.
    always_comb begin
        rd_data_byp = ret_hit ? ret_wdata : rd_data_rf;
        raw_pipe    = 1'b0;
        for (int s = NUM_FWD-1; s >= 0; s--) begin
            if (match[s]) begin
                rd_data_byp = fwd_wdata[s];
                raw_pipe    = ~fwd_ready[s];
            end
        end
    end

    // A stage match or a same-cycle retire already supplies the value.
    assign raw_sb = rd_en & addr_nz & sb_busy[rd_addr] & ~(|match) & ~ret_hit;
endmodule

module bypass_scoreboard_unit #(
    parameter int NUM_RPORTS = 2,
    parameter int NUM_FWD    = 3,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int NREG       = 32,
    parameter int CW         = 32
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_RPORTS-1:0]            rd_en,
    input  logic [NUM_RPORTS-1:0][AW-1:0]    rd_addr,
    input  logic [NUM_RPORTS-1:0][DW-1:0]    rd_data_rf,
    output logic [NUM_RPORTS-1:0][DW-1:0]    rd_data_byp,
    input  logic                             id_valid,
    input  logic                             id_issue,
    input  logic                             id_we,
    input  logic [AW-1:0]                    id_waddr,
    input  logic                             id_long,
    input  logic [NUM_FWD-1:0]               fwd_valid,
    input  logic [NUM_FWD-1:0]               fwd_we,
    input  logic [NUM_FWD-1:0]               fwd_ready,
    input  logic [NUM_FWD-1:0][AW-1:0]       fwd_waddr,
    input  logic [NUM_FWD-1:0][DW-1:0]       fwd_wdata,
    input  logic                             ret_valid,
    input  logic [AW-1:0]                    ret_waddr,
    input  logic [DW-1:0]                    ret_wdata,
    input  logic                             flush,
    input  logic                             cnt_clr,
    output logic                             stall,
    output logic [NREG-1:0]                  sb_busy,
    output logic [CW-1:0]                    stall_cnt
);
    typedef struct packed {
        logic          vld;
        logic [AW-1:0] addr;
    } sb_req_t;

    logic [NUM_RPORTS-1:0] raw_pipe_v;
    logic [NUM_RPORTS-1:0] raw_sb_v;
    logic                  waw;
    logic                  ret_id_hit;
    sb_req_t               set_req;
    sb_req_t               clr_req;
    logic [NREG-1:0]       sb_next;

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
        bypass_scoreboard_port #(
            .NUM_FWD (NUM_FWD),
            .AW      (AW),
            .DW      (DW),
            .NREG    (NREG)
        ) u_port (
            .rd_en       (rd_en[p]),
            .rd_addr     (rd_addr[p]),
            .rd_data_rf  (rd_data_rf[p]),
            .fwd_valid   (fwd_valid),
            .fwd_we      (fwd_we),
            .fwd_ready   (fwd_ready),
            .fwd_waddr   (fwd_waddr),
            .fwd_wdata   (fwd_wdata),
            .ret_valid   (ret_valid),
            .ret_waddr   (ret_waddr),
            .ret_wdata   (ret_wdata),
            .sb_busy     (sb_busy),
            .rd_data_byp (rd_data_byp[p]),
            .raw_pipe    (raw_pipe_v[p]),
            .raw_sb      (raw_sb_v[p])
        );
    end

    assign ret_id_hit = ret_valid & (ret_waddr == id_waddr);
    assign waw        = id_we & (id_waddr != '0) & sb_busy[id_waddr] & ~ret_id_hit;
    assign stall      = id_valid & ((|raw_pipe_v) | (|raw_sb_v) | waw);

    assign set_req.vld  = id_issue & ~stall & id_long & id_we & (id_waddr != '0);
    assign set_req.addr = id_waddr;
    assign clr_req.vld  = ret_valid & (ret_waddr != '0);
    assign clr_req.addr = ret_waddr;

    // Clear before set so a same-cycle retire and reissue leaves the new owner busy.
    always_comb begin
        sb_next = sb_busy;
        if (clr_req.vld) sb_next[clr_req.addr] = 1'b0;
        if (set_req.vld) sb_next[set_req.addr] = 1'b1;
        if (flush)       sb_next = '0;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sb_busy <= '0;
        else         sb_busy <= sb_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                         stall_cnt <= '0;
        else if (cnt_clr)                    stall_cnt <= '0;
        else if (stall && stall_cnt != '1)   stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_bypass_scoreboard_unit.sv
// Directed bench: stimulus pushes expectations, a negedge monitor pops and compares.

module tb_bypass_scoreboard_unit;
    localparam int NP = 2, NF = 3, AW = 5, DW = 32, NREG = 32, CW = 4;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [NP-1:0]          rd_en;
    logic [NP-1:0][AW-1:0]  rd_addr;
    logic [NP-1:0][DW-1:0]  rd_data_rf;
    logic [NP-1:0][DW-1:0]  rd_data_byp;
    logic                   id_valid, id_issue, id_we, id_long;
    logic [AW-1:0]          id_waddr;
    logic [NF-1:0]          fwd_valid, fwd_we, fwd_ready;
    logic [NF-1:0][AW-1:0]  fwd_waddr;
    logic [NF-1:0][DW-1:0]  fwd_wdata;
    logic                   ret_valid;
    logic [AW-1:0]          ret_waddr;
    logic [DW-1:0]          ret_wdata;
    logic                   flush, cnt_clr, stall;
    logic [NREG-1:0]        sb_busy;
    logic [CW-1:0]          stall_cnt;

    bypass_scoreboard_unit #(.NUM_RPORTS(NP), .NUM_FWD(NF), .AW(AW), .DW(DW), .NREG(NREG), .CW(CW)) dut (
        .clk(clk), .resetn(resetn), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_rf(rd_data_rf),
        .rd_data_byp(rd_data_byp), .id_valid(id_valid), .id_issue(id_issue), .id_we(id_we),
        .id_waddr(id_waddr), .id_long(id_long), .fwd_valid(fwd_valid), .fwd_we(fwd_we),
        .fwd_ready(fwd_ready), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .ret_valid(ret_valid),
        .ret_waddr(ret_waddr), .ret_wdata(ret_wdata), .flush(flush), .cnt_clr(cnt_clr),
        .stall(stall), .sb_busy(sb_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] M_B0 = 5'd1, M_B1 = 5'd2, M_ST = 5'd4, M_BUSY = 5'd8, M_CNT = 5'd16;
    localparam logic [31:0] RF0 = 32'hAAAA_0000, RF1 = 32'hBBBB_0000;

    typedef struct {
        string       name;
        logic [4:0]  mask;
        logic [31:0] b0, b1;
        logic        st;
        logic [31:0] busy;
        logic [3:0]  cnt;
    } exp_t;

    exp_t q[$];
    int ntests = 0, nfail = 0;

    task automatic push_exp(input string n, input logic [4:0] m, input logic [31:0] b0,
                            input logic [31:0] b1, input logic st, input logic [31:0] busy,
                            input logic [3:0] cnt);
        exp_t e;
        e.name = n; e.mask = m; e.b0 = b0; e.b1 = b1; e.st = st; e.busy = busy; e.cnt = cnt;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.mask[0]) begin
                ntests++;
                if (rd_data_byp[0] !== e.b0) begin
                    nfail++; $display("FAIL %s byp0: got %h want %h", e.name, rd_data_byp[0], e.b0);
                end
            end
            if (e.mask[1]) begin
                ntests++;
                if (rd_data_byp[1] !== e.b1) begin
                    nfail++; $display("FAIL %s byp1: got %h want %h", e.name, rd_data_byp[1], e.b1);
                end
            end
            if (e.mask[2]) begin
                ntests++;
                if (stall !== e.st) begin
                    nfail++; $display("FAIL %s stall: got %b want %b", e.name, stall, e.st);
                end
            end
            if (e.mask[3]) begin
                ntests++;
                if (sb_busy !== e.busy) begin
                    nfail++; $display("FAIL %s sb_busy: got %h want %h", e.name, sb_busy, e.busy);
                end
            end
            if (e.mask[4]) begin
                ntests++;
                if (stall_cnt !== e.cnt) begin
                    nfail++; $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.cnt);
                end
            end
        end
    end

    task automatic idle();
        rd_en = '0; rd_addr = '0; rd_data_rf[0] = RF0; rd_data_rf[1] = RF1;
        id_valid = 0; id_issue = 0; id_we = 0; id_waddr = '0; id_long = 0;
        fwd_valid = '0; fwd_we = '0; fwd_ready = '0; fwd_waddr = '0; fwd_wdata = '0;
        ret_valid = 0; ret_waddr = '0; ret_wdata = '0; flush = 0; cnt_clr = 0;
    endtask

    task automatic set_fwd(input int s, input logic v, input logic we, input logic rdy,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        fwd_valid[s] = v; fwd_we[s] = we; fwd_ready[s] = rdy; fwd_waddr[s] = a; fwd_wdata[s] = d;
    endtask

    task automatic issue_long(input logic [AW-1:0] a);
        id_valid = 1; id_issue = 1; id_we = 1; id_long = 1; id_waddr = a;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 0; idle();
        push_exp("reset", M_ST | M_BUSY | M_CNT, 0, 0, 0, 0, 0);
        tick();
        resetn = 1;

        // Forwarding priority
        idle(); id_valid = 1; rd_en = 2'b11; rd_addr[0] = 5; rd_addr[1] = 6;
        set_fwd(0, 1, 1, 1, 5, 32'h11); set_fwd(1, 1, 1, 1, 5, 32'h22); set_fwd(2, 1, 1, 1, 5, 32'h33);
        push_exp("fwd_exe", M_B0 | M_B1 | M_ST, 32'h11, RF1, 0, 0, 0);
        tick();
        fwd_valid[0] = 0;
        push_exp("fwd_mem", M_B0 | M_ST, 32'h22, 0, 0, 0, 0);
        tick();
        fwd_we[1] = 0;
        push_exp("fwd_wb", M_B0 | M_ST, 32'h33, 0, 0, 0, 0);
        tick();

        // Load-use interlock
        idle(); id_valid = 1; rd_en = 2'b01; rd_addr[0] = 7;
        set_fwd(0, 1, 1, 0, 7, 32'h99); set_fwd(1, 1, 1, 1, 7, 32'h44);
        push_exp("load_use", M_B0 | M_ST, 32'h99, 0, 1, 0, 0);
        tick();
        fwd_valid[0] = 0;
        push_exp("load_done", M_B0 | M_ST | M_CNT, 32'h44, 0, 0, 0, 1);
        tick();
        fwd_valid[0] = 1; id_valid = 0;
        push_exp("load_noid", M_ST, 0, 0, 0, 0, 1);
        tick();

        // Long op on r9
        idle(); issue_long(9);
        push_exp("div_issue", M_ST | M_BUSY, 0, 0, 0, 0, 1);
        tick();
        idle(); id_valid = 1; rd_en = 2'b01; rd_addr[0] = 9;
        push_exp("div_raw1", M_ST | M_BUSY | M_CNT, 0, 0, 1, 32'h200, 1);
        tick();
        id_issue = 1; id_we = 1; id_long = 1; id_waddr = 10;
        push_exp("div_raw2", M_ST | M_CNT, 0, 0, 1, 0, 2);
        tick();
        id_issue = 0; id_we = 0; id_long = 0; id_waddr = 0;
        ret_valid = 1; ret_waddr = 9; ret_wdata = 32'hDEAD;
        push_exp("div_ret", M_B0 | M_ST | M_BUSY | M_CNT, 32'hDEAD, 0, 0, 32'h200, 3);
        tick();
        ret_valid = 0;
        push_exp("div_after", M_B0 | M_ST | M_BUSY | M_CNT, RF0, 0, 0, 0, 3);
        tick();

        // WAW on r3
        idle(); issue_long(3);
        push_exp("waw_setup", M_ST, 0, 0, 0, 0, 3);
        tick();
        idle(); id_valid = 1; id_we = 1; id_waddr = 3;
        push_exp("waw_stall", M_ST | M_BUSY, 0, 0, 1, 32'h8, 3);
        tick();
        ret_valid = 1; ret_waddr = 3;
        push_exp("waw_ret", M_ST | M_CNT, 0, 0, 0, 0, 4);
        tick();

        // Same-cycle retire and reissue, then flush
        idle(); issue_long(4);
        push_exp("r4_issue", M_ST | M_BUSY, 0, 0, 0, 0, 4);
        tick();
        ret_valid = 1; ret_waddr = 4;
        push_exp("r4_reissue", M_ST | M_BUSY, 0, 0, 0, 32'h10, 4);
        tick();
        idle(); issue_long(9);
        push_exp("r4_kept", M_BUSY, 0, 0, 0, 32'h10, 4);
        tick();
        idle(); issue_long(7); flush = 1;
        push_exp("pre_flush", M_ST | M_BUSY, 0, 0, 0, 32'h210, 4);
        tick();
        idle(); issue_long(0); ret_valid = 1; ret_waddr = 0;
        push_exp("flushed", M_BUSY, 0, 0, 0, 0, 4);
        tick();
        idle();
        push_exp("r0_noop", M_BUSY, 0, 0, 0, 0, 4);
        tick();

        // r0 reads never forward or stall
        idle(); id_valid = 1; rd_en = 2'b11; ret_valid = 1; ret_wdata = 32'h5555;
        set_fwd(0, 1, 1, 0, 0, 32'h1); set_fwd(1, 1, 1, 1, 0, 32'h2); set_fwd(2, 1, 1, 1, 0, 32'h3);
        push_exp("r0_read", M_B0 | M_B1 | M_ST | M_CNT, RF0, RF1, 0, 0, 4);
        tick();

        // Counter saturation and clear
        idle(); id_valid = 1; rd_en = 2'b01; rd_addr[0] = 7; set_fwd(0, 1, 1, 0, 7, 32'h9);
        for (int i = 0; i < 11; i++) begin
            push_exp("cnt_ramp", M_ST | M_CNT, 0, 0, 1, 0, 4'(4 + i));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            push_exp("cnt_sat", M_ST | M_CNT, 0, 0, 1, 0, 4'd15);
            tick();
        end
        cnt_clr = 1;
        push_exp("cnt_clr_cyc", M_CNT, 0, 0, 1, 0, 4'd15);
        tick();
        cnt_clr = 0;
        push_exp("cnt_cleared", M_CNT, 0, 0, 1, 0, 4'd0);
        tick();
        idle();
        push_exp("cnt_one", M_ST | M_CNT, 0, 0, 0, 0, 4'd1);
        tick();

        // Async reset mid-operation
        issue_long(12);
        tick();
        idle();
        push_exp("busy12", M_BUSY, 0, 0, 0, 32'h1000, 1);
        tick();
        resetn = 0;
        push_exp("async_rst", M_BUSY | M_CNT, 0, 0, 0, 0, 0);
        tick();
        resetn = 1;
        push_exp("post_rst", M_BUSY | M_CNT, 0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            nfail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
